// File: rtl/conv3x3_layer_accumulator.sv
// Multi-kernel 3x3 dot-product engine: accumulates per-column partial sums across the input
// layers of a row and emits one NUM_KERNELS-wide result word per column after the last layer.
module conv3x3_layer_accumulator #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_KERNELS = 4,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned MAX_COLS    = 64
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [9:0]                      cfg_no_of_layers,
    input  logic [9:0]                      cfg_col_size,
    input  logic [9*DATA_W-1:0]             in_data,
    input  logic                            in_valid,
    output logic                            in_rdy,
    input  logic [9:0]                      in_id,
    input  logic [NUM_KERNELS*9*DATA_W-1:0] wt_data,
    input  logic                            wt_valid,
    output logic                            wt_rdy,
    output logic [NUM_KERNELS*ACC_W-1:0]    out_data,
    output logic                            out_valid,
    input  logic                            out_rdy,
    output logic [9:0]                      out_col,
    output logic [9:0]                      out_row,
    output logic                            out_last,
    output logic                            err_id_mismatch
);

    localparam int unsigned WIN_W  = 9 * DATA_W;
    localparam int unsigned MUL_W  = 2 * DATA_W;
    localparam int unsigned PROD_W = 2 * DATA_W + 4;
    localparam int unsigned LANE_W = NUM_KERNELS * ACC_W;
    localparam int unsigned COL_AW = $clog2(MAX_COLS);

    typedef enum logic {StWaitWt, StRun} state_e;

    state_e                         state_q, state_d;
    logic [9:0]                     col_q, col_d;
    logic [9:0]                     layer_q, layer_d;
    logic [9:0]                     row_q, row_d;
    logic [9:0]                     cfg_layers_q, cfg_cols_q;
    logic [NUM_KERNELS*WIN_W-1:0]   wt_q;
    logic [LANE_W-1:0]              out_data_q;
    logic                           out_valid_q;
    logic [9:0]                     out_col_q, out_row_q;
    logic                           out_last_q;
    logic                           err_q;

    // Accumulator buffer is deliberately left without reset; layer 0 never reads it.
    logic [LANE_W-1:0]              acc_mem [MAX_COLS];
    logic [LANE_W-1:0]              acc_rd;
    logic [LANE_W-1:0]              sum;
    logic signed [MUL_W-1:0]        prod;
    logic signed [PROD_W-1:0]       dot;
    logic                           last_layer, last_col, accept;

    assign last_layer = (layer_q == cfg_layers_q - 10'd1);
    assign last_col   = (col_q == cfg_cols_q - 10'd1);
    assign accept     = in_valid && in_rdy;
    assign acc_rd     = acc_mem[col_q[COL_AW-1:0]];

    always_comb begin
        sum  = '0;
        prod = '0;
        dot  = '0;
        for (int n = 0; n < int'(NUM_KERNELS); n++) begin
            dot = '0;
            for (int k = 0; k < 9; k++) begin
                prod = MUL_W'($signed(wt_q[WIN_W*n + DATA_W*k +: DATA_W]))
                     * MUL_W'($signed(in_data[DATA_W*k +: DATA_W]));
                dot  = dot + PROD_W'(prod);
            end
            sum[ACC_W*n +: ACC_W] = ((layer_q == 10'd0) ? '0 : acc_rd[ACC_W*n +: ACC_W])
                                  + ACC_W'(dot);
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        layer_d = layer_q;
        row_d   = row_q;
        wt_rdy  = 1'b0;
        in_rdy  = 1'b0;
        case (state_q)
            StWaitWt: begin
                wt_rdy = 1'b1;
                if (wt_valid) state_d = StRun;
            end
            StRun: begin
                // Only the last layer produces output, so only it can be stalled downstream.
                in_rdy = !last_layer || !out_valid_q || out_rdy;
                if (in_valid && in_rdy) begin
                    if (last_col) begin
                        col_d   = 10'd0;
                        state_d = StWaitWt;
                        if (last_layer) begin
                            layer_d = 10'd0;
                            row_d   = row_q + 10'd1;
                        end else begin
                            layer_d = layer_q + 10'd1;
                        end
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                end
            end
            default: state_d = StWaitWt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StWaitWt;
            col_q        <= 10'd0;
            layer_q      <= 10'd0;
            row_q        <= 10'd0;
            cfg_layers_q <= 10'd1;
            cfg_cols_q   <= 10'd1;
            wt_q         <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            layer_q <= layer_d;
            row_q   <= row_d;
            if (state_q == StWaitWt && wt_valid) begin
                wt_q <= wt_data;
                if (layer_q == 10'd0 && col_q == 10'd0) begin
                    cfg_layers_q <= cfg_no_of_layers;
                    cfg_cols_q   <= cfg_col_size;
                end
            end
            if (accept && in_id != layer_q) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && accept && !last_layer) acc_mem[col_q[COL_AW-1:0]] <= sum;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_col_q   <= 10'd0;
            out_row_q   <= 10'd0;
            out_last_q  <= 1'b0;
        end else if (accept && last_layer) begin
            out_data_q  <= sum;
            out_valid_q <= 1'b1;
            out_col_q   <= col_q;
            out_row_q   <= row_q;
            out_last_q  <= last_col;
        end else if (out_valid_q && out_rdy) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data        = out_data_q;
    assign out_valid       = out_valid_q;
    assign out_col         = out_col_q;
    assign out_row         = out_row_q;
    assign out_last        = out_last_q;
    assign err_id_mismatch = err_q;

endmodule
